// File: rtl/fpu_mul_pkg.sv
// ---------------------------------------------------------------------------
// fpu_mul_pkg
// Shared constants and types for the single-precision multiplier back end.
//   - IEEE-754 single-precision field widths and special encodings
//   - default mantissa / exponent-sum widths of the normalize/round pipeline
//   - S1 -> S2 payload struct carried between normalize and round/pack
//   - small helper to assemble a single-precision word from its fields
// ---------------------------------------------------------------------------
package fpu_mul_pkg;

    // Pipeline datapath widths (mantissa incl. hidden bit, signed exponent sum)
    localparam int SIZE_DATA_DEF = 24;
    localparam int SIZE_EXP_DEF  = 10;

    // IEEE-754 single-precision layout
    localparam int FP_WIDTH  = 32;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [FP_WIDTH-1:0] QNAN = 32'h7FC0_0000;

    // Normalized payload handed from S1 to S2. The exponent carries one
    // guard bit above the input width so the +1 from an over-range product
    // can never wrap.
    typedef struct packed {
        logic                           sign;
        logic signed [SIZE_EXP_DEF:0]   exp;
        logic [SIZE_DATA_DEF-1:0]       man;
        logic                           inc;
        logic                           nan;
        logic                           inf;
        logic                           zero;
    } s1_payload_t;

    // Assemble a single-precision word from sign, biased exponent and fraction
    function automatic logic [FP_WIDTH-1:0] fp_pack(
        input logic                 sign,
        input logic [FP_EXP_W-1:0]  exp,
        input logic [FP_FRAC_W-1:0] frac
    );
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/mul_round_inc.sv
// ---------------------------------------------------------------------------
// mul_round_inc
// Rounding incrementer with renormalization. Adds the round increment to the
// mantissa one bit wider than the mantissa; a carry-out means the mantissa
// rolled over to 2.0, so it is replaced by 1.0 and the exponent bumped.
// Ports:
//   i_man  [SIZE_DATA-1:0]   normalized mantissa (hidden bit at MSB)
//   i_inc                    round increment (0/1)
//   i_exp  [SIZE_EXP_W-1:0]  signed exponent
//   o_man  [SIZE_DATA-1:0]   rounded mantissa
//   o_exp  [SIZE_EXP_W:0]    signed exponent after renormalization
// ---------------------------------------------------------------------------
module mul_round_inc #(
    parameter int SIZE_DATA  = 24,
    parameter int SIZE_EXP_W = 11
) (
    input  logic [SIZE_DATA-1:0]         i_man,
    input  logic                         i_inc,
    input  logic signed [SIZE_EXP_W-1:0] i_exp,
    output logic [SIZE_DATA-1:0]         o_man,
    output logic signed [SIZE_EXP_W:0]   o_exp
);

    localparam logic [SIZE_DATA-1:0]       MAN_ONE = {1'b1, {(SIZE_DATA-1){1'b0}}};
    localparam logic signed [SIZE_EXP_W:0] EXP_ONE = {{SIZE_EXP_W{1'b0}}, 1'b1};

    logic [SIZE_DATA:0]          w_sum;
    logic signed [SIZE_EXP_W:0]  w_exp_ext;

    assign w_sum     = {1'b0, i_man} + {{SIZE_DATA{1'b0}}, i_inc};
    assign w_exp_ext = {i_exp[SIZE_EXP_W-1], i_exp};

    // Select rounded mantissa, renormalizing on carry-out
    always_comb begin
        o_man = w_sum[SIZE_DATA-1:0];
        o_exp = w_exp_ext;
        if (w_sum[SIZE_DATA]) begin
            o_man = MAN_ONE;
            o_exp = w_exp_ext + EXP_ONE;
        end else begin
            o_man = w_sum[SIZE_DATA-1:0];
            o_exp = w_exp_ext;
        end
    end

endmodule

// File: rtl/mul_norm_round.sv
// ---------------------------------------------------------------------------
// mul_norm_round
// Two-stage back end of a single-precision multiplier with valid/ready
// handshakes on both sides.
//   S1: normalize the raw mantissa product (shift right on bit-47 overflow)
//   S2: round (mul_round_inc), range check, special-case select, pack
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_valid / o_ready           upstream handshake
//   i_sign, i_exp, i_man,       product sign, biased exponent sum,
//   i_over, i_rnd               product bits [46:23], bit 47, round request
//   i_zero, i_inf, i_nan        operand special-case flags
//   o_valid / i_ready           downstream handshake
//   o_result                    IEEE-754 single-precision product
//   o_overflow, o_underflow     exception flags, qualified by o_valid
// ---------------------------------------------------------------------------
module mul_norm_round
    import fpu_mul_pkg::*;
#(
    parameter int SIZE_DATA = SIZE_DATA_DEF,
    parameter int SIZE_EXP  = SIZE_EXP_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_sign,
    input  logic [SIZE_EXP-1:0]  i_exp,
    input  logic [SIZE_DATA-1:0] i_man,
    input  logic                 i_over,
    input  logic                 i_rnd,
    input  logic                 i_zero,
    input  logic                 i_inf,
    input  logic                 i_nan,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [31:0]          o_result,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    localparam logic signed [SIZE_EXP:0]   EXP_ONE   = {{SIZE_EXP{1'b0}}, 1'b1};
    localparam logic signed [SIZE_EXP+1:0] EXP_MAX_S = (SIZE_EXP+2)'(EXP_MAX);
    localparam logic signed [SIZE_EXP+1:0] EXP_ZERO  = {(SIZE_EXP+2){1'b0}};

    logic                        r_s1_valid;
    s1_payload_t                 r_s1;
    logic                        r_s2_valid;
    logic [31:0]                 r_result;
    logic                        r_overflow;
    logic                        r_underflow;

    logic                        w_s1_advance;
    logic                        w_in_ready;
    s1_payload_t                 w_norm;
    logic [SIZE_DATA-1:0]        w_rnd_man;
    logic signed [SIZE_EXP+1:0]  w_rnd_exp;
    logic [31:0]                 w_result;
    logic                        w_overflow;
    logic                        w_underflow;

    // S1 may hand over when S2 is empty or S2 is being drained this cycle
    assign w_s1_advance = !r_s2_valid | i_ready;
    assign w_in_ready   = !r_s1_valid | w_s1_advance;
    assign o_ready      = w_in_ready;

    // S1 normalize: a product >= 2.0 shifts right one place and the bit
    // shifted out becomes the round increment
    always_comb begin
        w_norm.sign = i_sign;
        w_norm.nan  = i_nan;
        w_norm.inf  = i_inf;
        w_norm.zero = i_zero;
        w_norm.exp  = {i_exp[SIZE_EXP-1], i_exp};
        w_norm.man  = i_man;
        w_norm.inc  = i_rnd;
        if (i_over) begin
            w_norm.man = {1'b1, i_man[SIZE_DATA-1:1]};
            w_norm.exp = $signed({i_exp[SIZE_EXP-1], i_exp}) + EXP_ONE;
            w_norm.inc = i_man[0];
        end else begin
            w_norm.man = i_man;
            w_norm.exp = {i_exp[SIZE_EXP-1], i_exp};
            w_norm.inc = i_rnd;
        end
    end

    // S1 occupancy: refilled or emptied whenever the stage can take a new entry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= i_valid;
        end
    end

    // S1 payload: no reset needed, qualified by r_s1_valid
    always_ff @(posedge i_clk) begin
        if (w_in_ready && i_valid) begin
            r_s1 <= w_norm;
        end
    end

    mul_round_inc #(
        .SIZE_DATA  (SIZE_DATA),
        .SIZE_EXP_W (SIZE_EXP + 1)
    ) u_round_inc (
        .i_man (r_s1.man),
        .i_inc (r_s1.inc),
        .i_exp (r_s1.exp),
        .o_man (w_rnd_man),
        .o_exp (w_rnd_exp)
    );

    // S2 pack: specials take priority and raise no flags; otherwise range check
    always_comb begin
        w_result    = 32'h0000_0000;
        w_overflow  = 1'b0;
        w_underflow = 1'b0;
        if (r_s1.nan) begin
            w_result = QNAN;
        end else if (r_s1.inf) begin
            w_result = fp_pack(r_s1.sign, 8'hFF, 23'h00_0000);
        end else if (r_s1.zero) begin
            w_result = fp_pack(r_s1.sign, 8'h00, 23'h00_0000);
        end else if (w_rnd_exp >= EXP_MAX_S) begin
            w_result   = fp_pack(r_s1.sign, 8'hFF, 23'h00_0000);
            w_overflow = 1'b1;
        end else if (w_rnd_exp <= EXP_ZERO) begin
            // flush to zero, denormals are not produced
            w_result    = fp_pack(r_s1.sign, 8'h00, 23'h00_0000);
            w_underflow = 1'b1;
        end else begin
            w_result = fp_pack(r_s1.sign, w_rnd_exp[7:0],
                               w_rnd_man[SIZE_DATA-2 -: FP_FRAC_W]);
        end
    end

    // S2 / output register: holds while the downstream stalls
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid  <= 1'b0;
            r_result    <= 32'h0000_0000;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_s1_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result    <= w_result;
                r_overflow  <= w_overflow;
                r_underflow <= w_underflow;
            end
        end
    end

    assign o_valid     = r_s2_valid;
    assign o_result    = r_result;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule
